// File: rtl/read_pattern_source.sv
// read_pattern_source: 64-bit test-pattern generator feeding a 32-bit FIFO drained by okPipeOut.
// Define ERROR_INJECT_EN to let inject_error flip bit 0 of the next pushed word.
module read_pattern_source #(
  parameter int          DEPTH_LOG2   = 9,
  parameter logic [63:0] PATTERN_SEED = 64'h0000_0000_0000_0001
) (
  input  logic                  okClk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           pattern_sel,
  input  logic [31:0]           word_limit,
  input  logic                  pipe_out_read,
  output logic [31:0]           pipe_out_data,
  input  logic                  inject_error,
  output logic                  running,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [31:0]           words_generated,
  output logic [31:0]           underflow_count
);
  localparam int          LW   = DEPTH_LOG2 + 1;
  localparam logic [63:0] SEED = (PATTERN_SEED == 64'h0) ? 64'h1 : PATTERN_SEED;
  localparam logic [63:0] TAPS = 64'hB000_0000_0000_0001;
  localparam logic [63:0] ALT  = 64'hAAAA_AAAA_5555_5555;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]            sel;
  logic [31:0]           limit;
  logic [63:0]           pattern;
  logic                  phase, stop_pend;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [31:0]           mem [2**DEPTH_LOG2];
  logic                  full, empty, go, halt, lim_hit, push, pop, pair_done;
  logic [31:0]           push_data;

  function automatic logic [63:0] pat_init(input logic [1:0] s);
    return s == 2'd0 ? 64'h0 : s == 2'd1 ? SEED : s == 2'd2 ? 64'h1 : ALT;
  endfunction

  function automatic logic [63:0] pat_next(input logic [1:0] s, input logic [63:0] p);
    return s == 2'd0 ? p + 64'h1 :
           s == 2'd1 ? ({p[62:0], 1'b0} ^ (p[63] ? TAPS : 64'h0)) :
           s == 2'd2 ? {p[62:0], p[63]} : ~p;
  endfunction

  assign full      = fifo_level[DEPTH_LOG2];
  assign empty     = fifo_level == '0;
  assign go        = (state == IDLE || state == DONE) && start && !stop;
  assign halt      = stop || stop_pend;
  assign lim_hit   = limit != 32'h0 && words_generated == limit;
  // a stop seen on phase 0 must not open a new pair
  assign push      = state == RUN && !full && !lim_hit && !(halt && !phase);
  assign pop       = pipe_out_read && !empty;
  assign pair_done = push && phase;

`ifdef ERROR_INJECT_EN
  logic armed;
  always_ff @(posedge okClk or negedge reset_n)
    if (!reset_n) armed <= 1'b0;
    else armed <= (push && armed) ? 1'b0 : (armed || inject_error);
  assign push_data = (phase ? pattern[63:32] : pattern[31:0]) ^ {31'h0, armed};
`else
  logic unused_inject;
  assign unused_inject = inject_error;
  assign push_data = phase ? pattern[63:32] : pattern[31:0];
`endif

  logic unused_sel;
  assign unused_sel = ^pattern_sel[31:2];

  always_ff @(posedge okClk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = go ? RUN : state;
      RUN:        state_nxt = (lim_hit || (halt && (!phase || pair_done))) ? DRAIN : RUN;
      DRAIN:      state_nxt = empty ? DONE : DRAIN;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running = state == RUN || state == DRAIN;
    done    = state == DONE;
  end

  // remembers a stop that arrived while the closing phase-1 push was stalled by a full FIFO
  always_ff @(posedge okClk or negedge reset_n)
    if (!reset_n) stop_pend <= 1'b0;
    else stop_pend <= state == RUN && state_nxt == RUN && halt;

  always_ff @(posedge okClk or negedge reset_n)
    if (!reset_n) begin
      sel             <= 2'd0;
      limit           <= 32'h0;
      pattern         <= 64'h0;
      phase           <= 1'b0;
      words_generated <= 32'h0;
    end else if (go) begin
      sel             <= pattern_sel[1:0];
      limit           <= word_limit;
      pattern         <= pat_init(pattern_sel[1:0]);
      phase           <= 1'b0;
      words_generated <= 32'h0;
    end else if (push) begin
      phase <= ~phase;
      if (phase) begin
        pattern         <= pat_next(sel, pattern);
        words_generated <= words_generated + 32'h1;
      end
    end

  always_ff @(posedge okClk)
    if (push) mem[wr_ptr] <= push_data;

  always_ff @(posedge okClk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_level      <= '0;
      pipe_out_data   <= 32'h0;
      underflow_count <= 32'h0;
    end else begin
      wr_ptr     <= wr_ptr + DEPTH_LOG2'(push);
      rd_ptr     <= rd_ptr + DEPTH_LOG2'(pop);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (pop) pipe_out_data <= mem[rd_ptr];
      if (go) underflow_count <= 32'h0;
      else if (pipe_out_read && empty && underflow_count != 32'hFFFF_FFFF)
        underflow_count <= underflow_count + 32'h1;
    end
endmodule

// File: tb/tb_read_pattern_source.sv
// tb_read_pattern_source: scoreboard bench for the read-throughput pattern source.
module tb_read_pattern_source;
  logic        okClk = 0, reset_n = 0, start = 0, stop = 0, pipe_out_read = 0, inject_error = 0;
  logic [31:0] pattern_sel = 0, word_limit = 0;
  logic [31:0] pipe_out_data, words_generated, underflow_count;
  logic        running, done;
  logic [9:0]  fifo_level;

  read_pattern_source dut (
    .okClk(okClk), .reset_n(reset_n), .start(start), .stop(stop),
    .pattern_sel(pattern_sel), .word_limit(word_limit), .pipe_out_read(pipe_out_read),
    .pipe_out_data(pipe_out_data), .inject_error(inject_error), .running(running),
    .done(done), .fifo_level(fifo_level), .words_generated(words_generated),
    .underflow_count(underflow_count)
  );

  always #5 okClk = ~okClk;

  int          errors = 0, checks = 0;
  logic [31:0] sb[$];
  bit          pend = 0;

  function automatic logic [63:0] pinit(input logic [1:0] s);
    case (s)
      2'd0: return 64'h0;
      2'd1: return 64'h1;
      2'd2: return 64'h1;
      default: return 64'hAAAA_AAAA_5555_5555;
    endcase
  endfunction

  function automatic logic [63:0] pnext(input logic [1:0] s, input logic [63:0] p);
    case (s)
      2'd0: return p + 64'h1;
      2'd1: return p[63] ? ({p[62:0], 1'b0} ^ 64'hB000_0000_0000_0001) : {p[62:0], 1'b0};
      2'd2: return {p[62:0], p[63]};
      default: return ~p;
    endcase
  endfunction

  task automatic load_sb(input logic [1:0] s, input int n);
    logic [63:0] p;
    sb.delete();
    p = pinit(s);
    repeat (n) begin
      sb.push_back(p[31:0]);
      sb.push_back(p[63:32]);
      p = pnext(s, p);
    end
  endtask

  task automatic pulse_start(input logic [1:0] s, input logic [31:0] lim);
    @(negedge okClk);
    pattern_sel = {30'h0, s};
    word_limit = lim;
    start = 1;
    @(negedge okClk);
    start = 0;
  endtask

  // one cycle of the reader: reports the word popped on the previous edge, then issues the next read
  task automatic rd(input bit en, output bit got, output logic [31:0] d);
    @(negedge okClk);
    got = pend;
    d = pipe_out_data;
    pipe_out_read = en && fifo_level != 0;
    pend = pipe_out_read;
  endtask

  task automatic test_reset;
    reset_n = 0;
    repeat (2) @(negedge okClk);
    checks += 6;
    if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%0h exp=0", running); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0h exp=0", done); end
    if (fifo_level !== 10'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    if (words_generated !== 32'h0) begin errors++; $display("FAIL reset_wg got=%0d exp=0", words_generated); end
    if (underflow_count !== 32'h0) begin errors++; $display("FAIL reset_uf got=%0d exp=0", underflow_count); end
    if (pipe_out_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", pipe_out_data); end
    reset_n = 1;
  endtask

  task automatic test_underflow;
    repeat (3) begin @(negedge okClk); pipe_out_read = 1; end
    @(negedge okClk);
    pipe_out_read = 0;
    checks += 3;
    if (underflow_count !== 32'd3) begin errors++; $display("FAIL uf_count got=%0d exp=3", underflow_count); end
    if (pipe_out_data !== 32'h0) begin errors++; $display("FAIL uf_data got=%h exp=0", pipe_out_data); end
    if (fifo_level !== 10'd0) begin errors++; $display("FAIL uf_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_counter;
    bit got; logic [31:0] d, e; int n = 0;
    load_sb(2'd0, 4);
    pend = 0;
    pulse_start(2'd0, 32'd4);
    for (int c = 0; c < 200 && !(done && !pend); c++) begin
      rd(1, got, d);
      if (got) begin
        checks++;
        e = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        if (d !== e) begin errors++; $display("FAIL cnt_data[%0d] got=%h exp=%h", n, d, e); end
        n++;
      end
    end
    pipe_out_read = 0; pend = 0;
    checks += 5;
    if (n != 8) begin errors++; $display("FAIL cnt_words got=%0d exp=8", n); end
    if (done !== 1'b1) begin errors++; $display("FAIL cnt_done got=%0h exp=1", done); end
    if (words_generated !== 32'd4) begin errors++; $display("FAIL cnt_wg got=%0d exp=4", words_generated); end
    if (underflow_count !== 32'd0) begin errors++; $display("FAIL cnt_uf got=%0d exp=0", underflow_count); end
    if (fifo_level !== 10'd0) begin errors++; $display("FAIL cnt_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_walking;
    bit got, sent = 0; logic [31:0] d, e; int n = 0, c = 0;
    load_sb(2'd2, 1200);
    pend = 0;
    pulse_start(2'd2, 32'd0);
    while (c < 700 && fifo_level != 10'd512) begin @(negedge okClk); c++; end
    checks += 2;
    if (fifo_level !== 10'd512) begin errors++; $display("FAIL walk_full got=%0d exp=512", fifo_level); end
    if (running !== 1'b1) begin errors++; $display("FAIL walk_running got=%0h exp=1", running); end
    repeat (4) @(negedge okClk);
    checks += 2;
    if (fifo_level !== 10'd512) begin errors++; $display("FAIL walk_stall got=%0d exp=512", fifo_level); end
    if (words_generated !== 32'd256) begin errors++; $display("FAIL walk_wg got=%0d exp=256", words_generated); end
    for (c = 0; c < 4000 && !(done && !pend); c++) begin
      rd(1, got, d);
      if (got) begin
        checks++;
        e = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        if (d !== e) begin errors++; $display("FAIL walk_data[%0d] got=%h exp=%h", n, d, e); end
        if (n == 128) begin
          checks++;
          if (d !== 32'h1) begin errors++; $display("FAIL walk_wrap got=%h exp=00000001", d); end
        end
        n++;
      end
      stop = n >= 1000 && !sent;
      if (stop) sent = 1;
    end
    stop = 0; pipe_out_read = 0; pend = 0;
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL walk_done got=%0h exp=1", done); end
    if (n < 1000 || n % 2 != 0) begin errors++; $display("FAIL walk_count got=%0d exp=even>=1000", n); end
  endtask

  task automatic test_stop;
    bit got; logic [31:0] d, e; int n = 0, c = 0;
    load_sb(2'd3, 4);
    pend = 0;
    pulse_start(2'd3, 32'd0);
    while (c < 50 && fifo_level != 10'd3) begin @(negedge okClk); c++; end
    stop = 1;
    @(negedge okClk);
    stop = 0;
    checks += 3;
    if (fifo_level !== 10'd4) begin errors++; $display("FAIL stop_level got=%0d exp=4", fifo_level); end
    if (words_generated !== 32'd2) begin errors++; $display("FAIL stop_wg got=%0d exp=2", words_generated); end
    if (running !== 1'b1) begin errors++; $display("FAIL stop_drain got=%0h exp=1", running); end
    repeat (3) @(negedge okClk);
    checks++;
    if (fifo_level !== 10'd4) begin errors++; $display("FAIL stop_hold got=%0d exp=4", fifo_level); end
    for (c = 0; c < 100 && !(done && !pend); c++) begin
      rd(1, got, d);
      if (got) begin
        checks++;
        e = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        if (d !== e) begin errors++; $display("FAIL stop_data[%0d] got=%h exp=%h", n, d, e); end
        n++;
      end
    end
    pipe_out_read = 0; pend = 0;
    checks += 2;
    if (n != 4) begin errors++; $display("FAIL stop_words got=%0d exp=4", n); end
    if (done !== 1'b1) begin errors++; $display("FAIL stop_done got=%0h exp=1", done); end
    @(negedge okClk);
    start = 1; stop = 1;
    @(negedge okClk);
    start = 0; stop = 0;
    repeat (2) @(negedge okClk);
    checks += 3;
    if (done !== 1'b1) begin errors++; $display("FAIL both_done got=%0h exp=1", done); end
    if (running !== 1'b0) begin errors++; $display("FAIL both_running got=%0h exp=0", running); end
    if (words_generated !== 32'd2) begin errors++; $display("FAIL both_wg got=%0d exp=2", words_generated); end
  endtask

  task automatic test_reset_mid;
    bit got, sent = 0; logic [31:0] d, e; int n = 0, c = 0;
    pend = 0;
    pulse_start(2'd0, 32'd0);
    while (c < 400 && fifo_level < 10'd256) begin @(negedge okClk); c++; end
    #2 reset_n = 0;
    #1;
    checks += 6;
    if (running !== 1'b0) begin errors++; $display("FAIL areset_running got=%0h exp=0", running); end
    if (done !== 1'b0) begin errors++; $display("FAIL areset_done got=%0h exp=0", done); end
    if (fifo_level !== 10'd0) begin errors++; $display("FAIL areset_level got=%0d exp=0", fifo_level); end
    if (words_generated !== 32'h0) begin errors++; $display("FAIL areset_wg got=%0d exp=0", words_generated); end
    if (underflow_count !== 32'h0) begin errors++; $display("FAIL areset_uf got=%0d exp=0", underflow_count); end
    if (pipe_out_data !== 32'h0) begin errors++; $display("FAIL areset_data got=%h exp=0", pipe_out_data); end
    @(negedge okClk);
    reset_n = 1;
    load_sb(2'd1, 1000);
    pulse_start(2'd1, 32'd0);
    for (c = 0; c < 3000 && !(done && !pend); c++) begin
      rd(1, got, d);
      if (got) begin
        checks++;
        e = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        if (d !== e) begin errors++; $display("FAIL lfsr_data[%0d] got=%h exp=%h", n, d, e); end
        if (n < 2) begin
          checks++;
          if (d !== (n == 0 ? 32'h1 : 32'h0)) begin errors++; $display("FAIL lfsr_first[%0d] got=%h", n, d); end
        end
        n++;
      end
      stop = n >= 8 && !sent;
      if (stop) sent = 1;
    end
    stop = 0; pipe_out_read = 0; pend = 0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL lfsr_done got=%0h exp=1", done); end
  endtask

`ifdef ERROR_INJECT_EN
  task automatic test_inject;
    bit got; logic [31:0] d, e; int n = 0;
    load_sb(2'd0, 3);
    sb[2] = sb[2] ^ 32'h1;
    pend = 0;
    @(negedge okClk);
    pattern_sel = 0; word_limit = 3; start = 1;
    @(negedge okClk);
    start = 0;
    @(negedge okClk);
    inject_error = 1;
    @(negedge okClk);
    inject_error = 0;
    for (int c = 0; c < 100 && !(done && !pend); c++) begin
      rd(1, got, d);
      if (got) begin
        checks++;
        e = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        if (d !== e) begin errors++; $display("FAIL inj_data[%0d] got=%h exp=%h", n, d, e); end
        n++;
      end
    end
    pipe_out_read = 0; pend = 0;
    checks++;
    if (n != 6) begin errors++; $display("FAIL inj_words got=%0d exp=6", n); end
  endtask
`endif

  initial begin
    test_reset;
    test_underflow;
    test_counter;
    test_walking;
    test_stop;
    test_reset_mid;
`ifdef ERROR_INJECT_EN
    test_inject;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/read_pattern_source.md
Name: read_pattern_source

Overview:
- Data source for the host read-throughput test: generates 64-bit test-pattern words and buffers them as 32-bit words in an internal FIFO.
- The FIFO is drained by okPipeOut (ep_read / ep_datain). The host checks the pattern and counts errors.
- It is the read-direction counterpart of the pipe-in write test. Trigger and wire endpoints drive start/stop/pattern; wire-outs report status.

Parameters:
- DEPTH_LOG2, 9, log2 of internal FIFO depth in 32-bit words (default 512 words).
- PATTERN_SEED, 64'h0000_0000_0000_0001, LFSR seed; a value of 0 is replaced by 1.

Ports:
- okClk  input  1  sole clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle trigger pulse; begins a run.
- stop  input  1  one-cycle trigger pulse; ends a run early.
- pattern_sel  input  32  pattern select, latched on start; only [1:0] used.
- word_limit  input  32  number of 64-bit words per run, latched on start; 0 = unlimited.
- pipe_out_read  input  1  okPipeOut ep_read.
- pipe_out_data  output  32  okPipeOut ep_datain.
- inject_error  input  1  one-cycle pulse; used only with ERROR_INJECT_EN.
- running  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE.
- fifo_level  output  DEPTH_LOG2+1  current FIFO occupancy in 32-bit words.
- words_generated  output  32  64-bit words fully pushed this run.
- underflow_count  output  32  reads issued while FIFO empty; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, FIFO empty, phase 0, all outputs 0, pattern register = seed for pattern_sel 0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE / DONE, start=1, stop=0: latch pattern_sel and word_limit, load initial pattern, clear words_generated and underflow_count, go to RUN. FIFO contents are not flushed.
  - RUN: once words_generated reaches word_limit (limit non-zero), go to DRAIN.
  - RUN, stop=1: finish the in-flight pair if phase=1, then go to DRAIN. A half word is never left in the FIFO.
  - DRAIN: go to DONE once the FIFO is empty.
  - start while in RUN or DRAIN is ignored. stop in IDLE or DONE is ignored. start and stop in the same cycle: stop wins, start ignored.
- Push rule (RUN only): push one 32-bit word per cycle when FIFO not full.
  - phase 0 pushes pattern[31:0]; phase 1 pushes pattern[63:32].
  - After the phase-1 push: advance the pattern and increment words_generated.
  - When full: stall with pattern and phase held; resume on the next free slot with no skipped or repeated word.
  - A push and a pop in the same cycle are both allowed; fifo_level is unchanged.
- Patterns (advance once per 64-bit word):
  - 0: counter; starts at 0, +1, wraps from 2^64-1 to 0.
  - 1: 64-bit Galois LFSR, polynomial x^64+x^63+x^61+x^60+1, shift left, starts at seed.
  - 2: walking one; starts at 64'h1, rotate left 1, returns to 64'h1 after 64 words.
  - 3: alternating 64'hAAAA_AAAA_5555_5555 and its complement, starting with the former.
- Read side: standard FIFO with one-cycle read latency.
  - pipe_out_read sampled high with FIFO non-empty: pipe_out_data takes the head word on that edge and the word is popped.
  - Read while empty: pipe_out_data holds its previous value and underflow_count increments. Legal in every state.
- fifo_level and full/empty are registered and exact. Full = 2^DEPTH_LOG2 words.
- Sustained throughput is one word per cycle in each direction.

Optional Feature:
- ERROR_INJECT_EN defined:
  - An inject_error pulse arms a flag.
  - The next 32-bit word pushed is XORed with 32'h0000_0001 and the flag clears.
  - The pattern register itself is unaffected.
  - Further pulses while the flag is armed are absorbed.
- Not defined: inject_error is ignored; the pushed data path is pure pattern.

Test Plan:
- pattern_sel=0, word_limit=4, start, continuous reads -> data 0,0,1,0,2,0,3,0; words_generated=4; DONE after eighth read; no underflow.
- pattern_sel=2, word_limit=0, no reads -> fifo_level reaches 512 and stalls, running=1. Then read continuously -> walking one intact across the stall; word 64 low half = 32'h0000_0001.
- Read 3 times while IDLE with empty FIFO -> underflow_count=3, pipe_out_data=0.
- pattern_sel=3, stop pulse mid-run on phase 1 -> pair completes; FIFO holds an even number of words; DRAIN then DONE after reads. start+stop in the same cycle from DONE -> stays DONE.
- reset_n low mid-RUN with FIFO half full -> all outputs 0 immediately, FIFO empty. Restart with pattern_sel=1 -> first two words 32'h0000_0001, 32'h0000_0000.
- With ERROR_INJECT_EN, pattern 0, inject_error pulse before the third push -> sequence 0,0,32'h0000_0000 read as 32'h0000_0001, then 0; subsequent words clean.
